mul_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_iter_step.sv | 30 +++
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 tb/tb_mul_div_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared decode constants and enums for the HI/LO multiply/divide unit
package mdu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } mdu_state_e;

    // Encoding matches funct[1:0] of the mul/div group.
    typedef enum logic [1:0] {
        K_MULT,
        K_MULTU,
        K_DIV,
        K_DIVU
    } mdu_kind_e;

    function automatic logic is_hilo(input logic [31:0] instr);
        return (instr[31:26] == OP_SPECIAL) &&
               ((instr[5:2] == 4'b0110) || (instr[5:2] == 4'b0100));
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// rtl/mdu_iter_step.sv - one shift-add multiply step and one restoring divide step
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] mul_acc_o,
    output logic [2*WIDTH-1:0] div_acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    always_comb begin
        sum       = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        mul_acc_o = {sum, acc_i[WIDTH-1:1]};

        rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_i};
        if (diff[WIDTH]) begin
            div_acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end else begin
            div_acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit owning the HI/LO registers
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic             flush,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       result_reg_addr,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    mdu_kind_e          kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mul_acc, div_acc, prod_fix;
    logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d, done_q, done_d;
    logic [5:0]         funct;
    logic               hilo, accept, signed_op, a_neg, b_neg;
    logic               unused_instr_bits;

    assign funct             = instr[5:0];
    assign hilo              = is_hilo(instr);
    assign unused_instr_bits = ^{instr[25:16], instr[10:6]};

    assign busy   = (state_q != ST_IDLE);
    assign stall  = issue & hilo & busy;
    assign accept = issue & hilo & ~busy & ~flush;

    assign signed_op = ~funct[0];
    assign a_neg     = signed_op & rs_data[WIDTH-1];
    assign b_neg     = signed_op & rt_data[WIDTH-1];
    assign a_mag     = a_neg ? -rs_data : rs_data;
    assign b_mag     = b_neg ? -rt_data : rt_data;
    assign prod_fix  = q_neg_q ? -acc_q : acc_q;

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .opnd_i    (opnd_q),
        .mul_acc_o (mul_acc),
        .div_acc_o (div_acc)
    );

    always_comb begin
        result          = '0;
        result_reg_addr = '0;
        if (accept && funct == FN_MFHI) begin
            result          = hi_q;
            result_reg_addr = instr[15:11];
        end else if (accept && funct == FN_MFLO) begin
            result          = lo_q;
            result_reg_addr = instr[15:11];
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (funct)
                        FN_MTHI: hi_d = rs_data;
                        FN_MTLO: lo_d = rs_data;
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            kind_d  = mdu_kind_e'(funct[1:0]);
                            state_d = funct[1] ? ST_DIV : ST_MUL;
                            cnt_d   = CNT_W'(WIDTH - 1);
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            opnd_d  = b_mag;
                            // A zero divisor keeps the all-ones quotient unsigned-looking.
                            q_neg_d = (a_neg ^ b_neg) & (funct[1] ? |rt_data : 1'b1);
                            r_neg_d = a_neg;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d = (state_q == ST_MUL) ? mul_acc : div_acc;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                if (kind_q == K_MULT || kind_q == K_MULTU) begin
                    {hi_d, lo_d} = prod_fix;
                end else begin
                    lo_d = q_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = r_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kind_q  <= K_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit at WIDTH 32 and 8
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        issue = 1'b0, flush = 1'b0;
    logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
    logic        stall, busy, done;
    logic [31:0] result, hi, lo;
    logic [4:0]  rra;

    logic        issue8 = 1'b0, flush8 = 1'b0;
    logic [31:0] instr8 = '0;
    logic [7:0]  rs8 = '0, rt8 = '0;
    logic        stall8, busy8, done8;
    logic [7:0]  result8, hi8, lo8;
    logic [4:0]  rra8;

    int total = 0;
    int bad = 0;

    mul_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .issue(issue), .flush(flush), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .busy(busy), .done(done),
        .result(result), .result_reg_addr(rra), .hi(hi), .lo(lo)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .issue(issue8), .flush(flush8), .instr(instr8),
        .rs_data(rs8), .rt_data(rt8), .stall(stall8), .busy(busy8), .done(done8),
        .result(result8), .result_reg_addr(rra8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] fn, input logic [4:0] rd);
        return {6'b000000, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    // Reference: plain integer arithmetic on sign-extended operands.
    function automatic void model(input int w, input logic [1:0] kind, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] mhi, output logic [31:0] mlo);
        longint sa, sb, q, r;
        logic [63:0] p, mask;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'({32'd0, a} & mask);
        sb = longint'({32'd0, b} & mask);
        if (!kind[0]) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        if (!kind[1]) begin
            p   = 64'(sa * sb);
            mhi = 32'((p >> w) & mask);
            mlo = 32'(p & mask);
        end else if (sb == 0) begin
            mlo = 32'(mask);
            mhi = 32'({32'd0, a} & mask);
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            mlo = 32'(64'(q) & mask);
            mhi = 32'(64'(r) & mask);
        end
    endfunction

    function automatic logic cur_busy(input int w);
        return (w == 32) ? busy : busy8;
    endfunction
    function automatic logic cur_done(input int w);
        return (w == 32) ? done : done8;
    endfunction
    function automatic logic [31:0] cur_hi(input int w);
        return (w == 32) ? hi : {24'd0, hi8};
    endfunction
    function automatic logic [31:0] cur_lo(input int w);
        return (w == 32) ? lo : {24'd0, lo8};
    endfunction

    task automatic run_op(input int w, input logic [1:0] kind, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [31:0] ehi, elo;
        int n;
        model(w, kind, a, b, ehi, elo);
        if (w == 32) begin
            instr = enc({4'b0110, kind}, 5'd0); rs_data = a; rt_data = b; issue = 1'b1;
        end else begin
            instr8 = enc({4'b0110, kind}, 5'd0); rs8 = a[7:0]; rt8 = b[7:0]; issue8 = 1'b1;
        end
        @(posedge clk); #1;
        issue = 1'b0; issue8 = 1'b0;
        n = 0;
        while (cur_busy(w) && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(w + 1));
        check({tag, " done"}, 64'(cur_done(w)), 64'd1);
        check({tag, " hi"}, 64'(cur_hi(w)), 64'(ehi));
        check({tag, " lo"}, 64'(cur_lo(w)), 64'(elo));
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 64'(cur_done(w)), 64'd0);
    endtask

    initial begin
        logic [1:0]  k;
        logic [31:0] a, b, ehi, elo, hi0, lo0;
        int n;
        logic ok, saw;

        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst rra", 64'(rra), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32, 2'b00, 32'hFFFF_FFFD, 32'd7, "mult_m3x7");
        check("mult_m3x7 hi const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_m3x7 lo const", 64'(lo), 64'hFFFF_FFEB);
        run_op(32, 2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
        run_op(32, 2'b11, 32'd7, 32'd0, "divu_7d0");
        run_op(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        run_op(32, 2'b10, 32'hFFFF_FFF9, 32'd0, "div_neg_d0");

        for (int i = 0; i < 16; i++) begin
            k = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            run_op(32, k, a, b, $sformatf("rnd32_%0d", i));
        end

        instr = enc(FN_MTLO, 5'd0); rs_data = 32'h1234; issue = 1'b1;
        @(posedge clk); #1;
        instr = enc(FN_MFLO, 5'd7); #1;
        check("mtlo_mflo result", 64'(result), 64'h1234);
        check("mtlo_mflo rra", 64'(rra), 64'd7);
        hi0 = hi;
        instr = enc(FN_MFHI, 5'd8); #1;
        check("mfhi result", 64'(result), 64'(hi0));
        @(posedge clk); #1;
        issue = 1'b0;

        a = $urandom; b = $urandom;
        model(32, 2'b01, a, b, ehi, elo);
        instr = enc(FN_MULTU, 5'd0); rs_data = a; rt_data = b; issue = 1'b1;
        @(posedge clk); #1;
        issue = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        instr = enc(FN_MFLO, 5'd9); issue = 1'b1; #1;
        ok = 1'b1; n = 0;
        while (busy && n < 200) begin
            if (!stall || result != 32'd0) ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("mflo_wait stalled", 64'(ok), 64'd1);
        check("mflo_wait done", 64'(done), 64'd1);
        check("mflo_wait stall_off", 64'(stall), 64'd0);
        check("mflo_wait result", 64'(result), 64'(elo));
        check("mflo_wait rra", 64'(rra), 64'd9);
        @(posedge clk); #1;
        issue = 1'b0;

        hi0 = hi; lo0 = lo;
        instr = enc(FN_DIV, 5'd0); rs_data = 32'd100; rt_data = 32'd7; issue = 1'b1;
        @(posedge clk); #1;
        issue = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        instr = 32'h0000_0020; issue = 1'b1; #1;
        check("other_instr stall", 64'(stall), 64'd0);
        instr = enc(FN_MFHI, 5'd3); #1;
        check("mfhi_busy stall", 64'(stall), 64'd1);
        check("mfhi_busy result", 64'(result), 64'd0);
        flush = 1'b1; instr = enc(FN_DIV, 5'd0);
        @(posedge clk); #1;
        flush = 1'b0; issue = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush hi", 64'(hi), 64'(hi0));
        check("flush lo", 64'(lo), 64'(lo0));
        saw = 1'b0;
        repeat (40) begin
            if (done || busy) saw = 1'b1;
            @(posedge clk); #1;
        end
        check("flush no_done", 64'(saw), 64'd0);
        flush = 1'b1; instr = enc(FN_MULT, 5'd0); issue = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; issue = 1'b0;
        check("flush_issue busy", 64'(busy), 64'd0);

        run_op(8, 2'b01, 32'hFF, 32'hFF, "w8_multu_ff");
        check("w8 hi const", 64'(hi8), 64'hFE);
        check("w8 lo const", 64'(lo8), 64'h01);
        for (int i = 0; i < 8; i++) begin
            k = 2'($urandom_range(0, 3));
            a = $urandom & 32'hFF;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom & 32'hFF);
            run_op(8, k, a, b, $sformatf("rnd8_%0d", i));
        end
        run_op(8, 2'b10, 32'h80, 32'hFF, "w8_div_min_m1");

        instr = enc(FN_MULT, 5'd0); rs_data = 32'd5; rt_data = 32'd6; issue = 1'b1;
        @(posedge clk); #1;
        issue = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid busy", 64'(busy), 64'd0);
        check("rst_mid done", 64'(done), 64'd0);
        check("rst_mid hi", 64'(hi), 64'd0);
        check("rst_mid lo", 64'(lo), 64'd0);
        check("rst_mid stall", 64'(stall), 64'd0);
        check("rst_mid result", 64'(result), 64'd0);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid stays_idle", 64'({busy, done}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
